// File: rtl/notifier_event_logger.sv
// Turns notifier register toggles from timing checks into timestamped events
// queued in a small show-ahead FIFO, with saturating per-channel violation counts.
module notifier_event_logger #(
  parameter int NCHAN  = 8,
  parameter int CHAN_W = 3,
  parameter int CNT_W  = 8,
  parameter int TS_W   = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NCHAN-1:0]  notifier_i,
  input  logic              enable_i,
  input  logic              clear_i,
  output logic              ev_valid_o,
  input  logic              ev_ready_i,
  output logic [CHAN_W-1:0] ev_chan_o,
  output logic [TS_W-1:0]   ev_time_o,
  output logic              ev_lost_o,
  input  logic [CHAN_W-1:0] cnt_sel_i,
  output logic [CNT_W-1:0]  cnt_value_o,
  output logic              any_violation_o
);

  localparam int AW = $clog2(DEPTH);

  logic [NCHAN-1:0]  sync1_q, sync2_q, prev_q, pending_q, pending_d;
  logic [NCHAN-1:0]  toggle, cand, pushed;
  logic [CNT_W-1:0]  cnt_q [NCHAN];
  logic [TS_W-1:0]   ts_q;
  logic [CHAN_W-1:0] memChan_q [DEPTH];
  logic [TS_W-1:0]   memTime_q [DEPTH];
  logic [AW:0]       wrPtr_q, rdPtr_q;
  logic              evLost_q, anyViol_q;
  logic [CNT_W-1:0]  cntValue_q;
  logic [CHAN_W-1:0] pushIdx;
  logic              doPush, doPop, full, empty, lostHit, anyNz;
  logic [CNT_W-1:0]  selCnt;

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  always_comb begin
    toggle  = (sync2_q ^ prev_q) & {NCHAN{enable_i}};
    cand    = pending_q | toggle;
    empty   = (wrPtr_q == rdPtr_q);
    full    = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    doPop   = !empty && ev_ready_i;
    pushIdx = '0;
    pushed  = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (cand[i]) begin
        pushIdx   = CHAN_W'(i);
        pushed    = '0;
        pushed[i] = 1'b1;
      end
    end
    doPush = (|cand) && (!full || doPop);
    if (!doPush) pushed = '0;
    lostHit   = |(toggle & pending_q & ~pushed);
    pending_d = (pending_q | toggle) & ~pushed;
  end

  always_comb begin
    selCnt = '0;
    anyNz  = 1'b0;
    for (int i = 0; i < NCHAN; i++) begin
      if (cnt_sel_i == CHAN_W'(i)) selCnt = cnt_q[i];
      if (cnt_q[i] != '0) anyNz = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      pending_q  <= '0;
      ts_q       <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      evLost_q   <= 1'b0;
      anyViol_q  <= 1'b0;
      cntValue_q <= '0;
      for (int i = 0; i < NCHAN; i++) cnt_q[i] <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        memChan_q[i] <= '0;
        memTime_q[i] <= '0;
      end
    end else begin
      sync1_q    <= notifier_i;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      ts_q       <= ts_q + TS_W'(1);
      cntValue_q <= selCnt;
      anyViol_q  <= anyNz;
      // Clear wipes logging state but leaves the sampler and timestamp running.
      if (clear_i) begin
        pending_q <= '0;
        wrPtr_q   <= '0;
        rdPtr_q   <= '0;
        evLost_q  <= 1'b0;
        for (int i = 0; i < NCHAN; i++) cnt_q[i] <= '0;
      end else begin
        pending_q <= pending_d;
        if (doPush) begin
          memChan_q[wrPtr_q[AW-1:0]] <= pushIdx;
          memTime_q[wrPtr_q[AW-1:0]] <= ts_q;
          wrPtr_q <= wrPtr_q + (AW+1)'(1);
        end
        if (doPop) rdPtr_q <= rdPtr_q + (AW+1)'(1);
        if (lostHit) evLost_q <= 1'b1;
        for (int i = 0; i < NCHAN; i++) begin
          if (toggle[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign ev_valid_o      = !empty;
  assign ev_chan_o       = memChan_q[rdPtr_q[AW-1:0]];
  assign ev_time_o       = memTime_q[rdPtr_q[AW-1:0]];
  assign ev_lost_o       = evLost_q;
  assign cnt_value_o     = cntValue_q;
  assign any_violation_o = anyViol_q;

endmodule

// File: tb/tb_notifier_event_logger.sv
// Directed scenarios for notifier_event_logger: latency, ordering, backpressure,
// lost-event flag, saturation, clear, enable gating and asynchronous reset.
module tb_notifier_event_logger;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] notif = '0;
  logic       enable = 1'b1;
  logic       clear = 1'b0;
  logic       evReady = 1'b1;
  logic [2:0] cntSel = '0;
  logic       evValid, evLost, anyViolation;
  logic [2:0] evChan;
  logic [15:0] evTime;
  logic [7:0] cntValue;

  int errors = 0;
  int checks = 0;

  notifier_event_logger dut (
    .clk_i(clk), .rst_i(rst), .notifier_i(notif), .enable_i(enable),
    .clear_i(clear), .ev_valid_o(evValid), .ev_ready_i(evReady),
    .ev_chan_o(evChan), .ev_time_o(evTime), .ev_lost_o(evLost),
    .cnt_sel_i(cntSel), .cnt_value_o(cntValue), .any_violation_o(anyViolation)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; notif = '0;
    tick(2);
    checks++; if (evValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", evValid); end
    checks++; if (evChan !== 3'd0) begin errors++; $display("[TB] FAIL reset_chan: got %0d expected 0", evChan); end
    checks++; if (evTime !== 16'd0) begin errors++; $display("[TB] FAIL reset_time: got %0d expected 0", evTime); end
    checks++; if (evLost !== 1'b0) begin errors++; $display("[TB] FAIL reset_lost: got %0b expected 0", evLost); end
    checks++; if (cntValue !== 8'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", cntValue); end
    checks++; if (anyViolation !== 1'b0) begin errors++; $display("[TB] FAIL reset_anyviol: got %0b expected 0", anyViolation); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // First edge after reset release is edge 0; timestamp after edge k is k+1.
  task automatic test_basic;
    evReady = 1'b1; cntSel = 3'd2;
    tick(10);
    notif[2] = 1'b1;
    tick(2);
    checks++; if (evValid !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_valid: got %0b expected 0", evValid); end
    tick(1);
    checks++; if (evValid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %0b expected 1", evValid); end
    checks++; if (evChan !== 3'd2) begin errors++; $display("[TB] FAIL basic_chan: got %0d expected 2", evChan); end
    checks++; if (evTime !== 16'd12) begin errors++; $display("[TB] FAIL basic_time: got %0d expected 12", evTime); end
    tick(1);
    checks++; if (evValid !== 1'b0) begin errors++; $display("[TB] FAIL basic_popped: got %0b expected 0", evValid); end
    checks++; if (cntValue !== 8'd1) begin errors++; $display("[TB] FAIL basic_cnt: got %0d expected 1", cntValue); end
    checks++; if (anyViolation !== 1'b1) begin errors++; $display("[TB] FAIL basic_anyviol: got %0b expected 1", anyViolation); end
  endtask

  task automatic test_same_cycle;
    logic [15:0] firstTime;
    evReady = 1'b1;
    notif[5] = ~notif[5]; notif[1] = ~notif[1];
    tick(3);
    firstTime = evTime;
    checks++; if (evValid !== 1'b1 || evChan !== 3'd1) begin errors++; $display("[TB] FAIL pair_first: got valid=%0b chan=%0d expected valid=1 chan=1", evValid, evChan); end
    tick(1);
    checks++; if (evValid !== 1'b1 || evChan !== 3'd5) begin errors++; $display("[TB] FAIL pair_second: got valid=%0b chan=%0d expected valid=1 chan=5", evValid, evChan); end
    checks++; if (evTime !== firstTime + 16'd1) begin errors++; $display("[TB] FAIL pair_time: got %0d expected %0d", evTime, firstTime + 16'd1); end
    tick(1);
    checks++; if (evValid !== 1'b0) begin errors++; $display("[TB] FAIL pair_drained: got %0b expected 0", evValid); end
  endtask

  task automatic test_backlog;
    evReady = 1'b0;
    notif[5:0] = ~notif[5:0];
    tick(10);
    checks++; if (evValid !== 1'b1 || evChan !== 3'd0) begin errors++; $display("[TB] FAIL backlog_head: got valid=%0b chan=%0d expected valid=1 chan=0", evValid, evChan); end
    evReady = 1'b1;
    for (int k = 0; k < 6; k++) begin
      checks++; if (evValid !== 1'b1 || evChan !== 3'(k)) begin errors++; $display("[TB] FAIL backlog_order: got valid=%0b chan=%0d expected valid=1 chan=%0d", evValid, evChan, k); end
      tick(1);
    end
    checks++; if (evValid !== 1'b0) begin errors++; $display("[TB] FAIL backlog_empty: got %0b expected 0", evValid); end
    checks++; if (evLost !== 1'b0) begin errors++; $display("[TB] FAIL backlog_lost: got %0b expected 0", evLost); end
  endtask

  task automatic test_lost;
    logic [2:0] expChan [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd7};
    evReady = 1'b0; cntSel = 3'd7;
    notif[3:0] = ~notif[3:0];
    tick(8);
    notif[7] = ~notif[7];
    tick(1);
    notif[7] = ~notif[7];
    tick(6);
    checks++; if (evLost !== 1'b1) begin errors++; $display("[TB] FAIL lost_flag: got %0b expected 1", evLost); end
    checks++; if (cntValue !== 8'd2) begin errors++; $display("[TB] FAIL lost_cnt7: got %0d expected 2", cntValue); end
    evReady = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (evValid !== 1'b1 || evChan !== expChan[k]) begin errors++; $display("[TB] FAIL lost_order: got valid=%0b chan=%0d expected valid=1 chan=%0d", evValid, evChan, expChan[k]); end
      tick(1);
    end
    checks++; if (evValid !== 1'b0) begin errors++; $display("[TB] FAIL lost_single7: got valid=%0b expected 0", evValid); end
  endtask

  task automatic test_saturate_clear;
    evReady = 1'b1; cntSel = 3'd3;
    for (int k = 0; k < 300; k++) begin
      notif[3] = ~notif[3];
      tick(1);
    end
    tick(6);
    checks++; if (cntValue !== 8'd255) begin errors++; $display("[TB] FAIL sat_cnt: got %0d expected 255", cntValue); end
    evReady = 1'b0;
    notif[6] = ~notif[6];
    tick(5);
    checks++; if (evValid !== 1'b1) begin errors++; $display("[TB] FAIL preclear_valid: got %0b expected 1", evValid); end
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(1);
    checks++; if (cntValue !== 8'd0) begin errors++; $display("[TB] FAIL clear_cnt: got %0d expected 0", cntValue); end
    checks++; if (evValid !== 1'b0) begin errors++; $display("[TB] FAIL clear_valid: got %0b expected 0", evValid); end
    checks++; if (evLost !== 1'b0) begin errors++; $display("[TB] FAIL clear_lost: got %0b expected 0", evLost); end
    checks++; if (anyViolation !== 1'b0) begin errors++; $display("[TB] FAIL clear_anyviol: got %0b expected 0", anyViolation); end
  endtask

  task automatic test_enable;
    evReady = 1'b1; cntSel = 3'd4; enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      notif[4] = ~notif[4];
      tick(2);
    end
    tick(4);
    checks++; if (evValid !== 1'b0) begin errors++; $display("[TB] FAIL disabled_valid: got %0b expected 0", evValid); end
    checks++; if (cntValue !== 8'd0) begin errors++; $display("[TB] FAIL disabled_cnt4: got %0d expected 0", cntValue); end
    enable = 1'b1;
    tick(4);
    checks++; if (evValid !== 1'b0) begin errors++; $display("[TB] FAIL reenable_valid: got %0b expected 0", evValid); end
  endtask

  task automatic test_async_reset;
    evReady = 1'b0;
    notif[1:0] = ~notif[1:0];
    tick(6);
    checks++; if (evValid !== 1'b1) begin errors++; $display("[TB] FAIL queued_valid: got %0b expected 1", evValid); end
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (evValid !== 1'b0) begin errors++; $display("[TB] FAIL async_rst_valid: got %0b expected 0", evValid); end
    checks++; if (evLost !== 1'b0) begin errors++; $display("[TB] FAIL async_rst_lost: got %0b expected 0", evLost); end
    notif = '0;
    tick(2);
    @(negedge clk);
    rst = 1'b0;
    tick(5);
    checks++; if (evValid !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_valid: got %0b expected 0", evValid); end
  endtask

  initial begin
    $display("[TB] starting notifier_event_logger bench");
    test_reset;
    test_basic;
    test_same_cycle;
    test_backlog;
    test_lost;
    test_saturate_clear;
    test_enable;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/notifier_event_logger.md
Name: notifier_event_logger

Overview:
- Consumes the notifier registers toggled by specify-block timing checks ($setup, $hold, $recovery, $removal, $width, $setuphold, $recrem) in the cell under test.
- Converts each notifier toggle into a timestamped violation event in a small FIFO and keeps a saturating violation count per channel.
- Testbenches and the regression harness drain events through a valid/ready port instead of polling notifier regs.

Parameters:
- NCHAN, 8: number of notifier inputs.
- CHAN_W, 3: channel index width; must satisfy 2**CHAN_W >= NCHAN.
- CNT_W, 8: per-channel violation counter width.
- TS_W, 16: timestamp width.
- DEPTH, 4: event FIFO depth (power of 2, >= 2).

Ports:
- clk  in  1  sampling clock.
- rst  in  1  asynchronous, active-high reset.
- notifier  in  NCHAN  notifier regs; any level change is one violation.
- enable  in  1  when low, toggles are ignored (tracked, not logged).
- clear  in  1  synchronous clear of counters, FIFO, pending mask, ev_lost.
- ev_valid  out  1  FIFO head valid.
- ev_ready  in  1  consumer accepts head.
- ev_chan  out  CHAN_W  channel of head event.
- ev_time  out  TS_W  timestamp of head event.
- ev_lost  out  1  sticky: a toggle merged into an already-pending event.
- cnt_sel  in  CHAN_W  counter readout select.
- cnt_value  out  CNT_W  registered count of channel cnt_sel.
- any_violation  out  1  registered OR of all counters nonzero.

Behaviour:
- Reset (async, rst=1): all outputs 0. sync1, sync2, prev, pending, FIFO pointers, counters and timestamp are 0.
- Sampling: notifier passes through 2-flop sync (sync1 -> sync2). toggle = (sync2 ^ prev) & {NCHAN{enable}}; prev <= sync2 every cycle, regardless of enable.
- The first compare after reset is against prev=0. A notifier that is 1 at reset release therefore logs one event; benches must drive notifier to 0 during reset.
- Timestamp: free-running TS_W counter, +1 per cycle, wraps to 0. Not affected by clear.
- Counters: on toggle[i], cnt[i] += 1, saturating at all-ones with no wrap.
- pending mask: pending <= (pending | toggle) & ~pushed.
  - If toggle[i] and pending[i] are both already set (and bit i is not pushed that cycle), ev_lost <= 1. The counter still increments.
- Push: each cycle with (pending | toggle) != 0 and FIFO not full, push the lowest-index set bit. The entry is {chan, current timestamp}; that bit is cleared from pending.
  - At most one push per cycle.
  - FIFO full: pending bits wait; nothing is dropped.
- Latency: a notifier change captured by sync1 at edge n gives toggle in cycle n+2. With FIFO empty and no lower-index pending bit, the push occurs at edge n+2 and ev_valid=1 from cycle n+3. ev_time equals the timestamp value during cycle n+2.
- FIFO: show-ahead. ev_chan and ev_time are stable while ev_valid=1 and ev_ready=0.
  - Pop on ev_valid & ev_ready.
  - Push and pop in the same cycle on a full FIFO are both allowed; occupancy is unchanged.
  - Pop on empty has no effect.
- clear: takes priority over everything except rst. Next cycle: counters=0, FIFO empty, pending=0, ev_lost=0. Toggles detected in the clear cycle are discarded; prev still updates.
- cnt_value, any_violation: registered, one cycle after cnt_sel or counter change. cnt_sel >= NCHAN reads 0.
- Reset mid-operation: immediate return to reset state; in-flight events are lost without setting ev_lost.

Test Plan:
- Reset with notifier=0; toggle notifier[2] 0->1 at edge 10, ev_ready=1 -> ev_valid=1 in cycle 13, ev_chan=2, ev_time=12; cnt_sel=2 gives cnt_value=1; any_violation=1.
- Toggle notifier[5] and notifier[1] in the same cycle -> two events in consecutive cycles, chan 1 then chan 5; ev_time differs by 1.
- Hold ev_ready=0 and toggle channels 0..5 once each -> 4 events queued, 2 pending. Release ev_ready -> all 6 delivered in order 0..5; ev_lost=0.
- With ev_ready=0 and FIFO full, toggle channel 7 twice -> ev_lost=1; cnt[7]=2; exactly one channel-7 event is delivered.
- Toggle channel 3 300 times with CNT_W=8 -> cnt_value=255 (saturated). Assert clear -> cnt_value=0, ev_valid=0, ev_lost=0, any_violation=0.
- enable=0 while toggling channel 4 -> no events and cnt[4]=0. Assert rst while events are queued -> ev_valid=0 immediately (asynchronous).
